rr_arbiter_nch: RTL and testbench
=================================

// Module: rr_arbiter_nch
//
// PURPOSE
//   N-channel round-robin arbiter with valid/ready handshake on every source and on the sink.
//   Successor of the 2-input arbiter: parametrised channel count, registered output stage
//   (full throughput, 1-cycle latency), winner-ID output and optional packet-lock mode.
//   It sits between multiple request producers and one shared downstream consumer.
//
// PARAMETERS
//   NUM_CH      4    number of source channels, >= 2
//   DATA_WIDTH  16   payload width per channel
//   PKT_MODE    0    0: arbitrate every beat; 1: hold the grant until a beat with last=1 is accepted
//   ID_W        $clog2(NUM_CH)   localparam, width of the channel index
//
// PORTS
//   aclk          in   1                  clock; all logic on the rising edge
//   areset_n      in   1                  asynchronous, active-low reset
//   src_valid_i   in   NUM_CH             per-channel valid
//   src_ready_o   out  NUM_CH             per-channel ready; at most one bit is set (one-hot or zero)
//   src_data_i    in   NUM_CH*DATA_WIDTH  channel i is in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   src_last_i    in   NUM_CH             end-of-packet marker; ignored when PKT_MODE=0
//   dst_valid_o   out  1                  registered output valid
//   dst_ready_i   in   1                  sink ready
//   dst_data_o    out  DATA_WIDTH         registered winner payload
//   dst_last_o    out  1                  registered last marker of the winner beat
//   dst_id_o      out  ID_W               registered index of the winning channel
//
// BEHAVIOUR
//   - Reset (async assert, sync-safe deassert): dst_valid_o=0, dst_data_o=0, dst_last_o=0,
//     dst_id_o=0, last_grant=NUM_CH-1 (channel 0 has highest priority first), lock=0.
//     Reset during a transfer drops the output beat; the source is not re-notified.
//   - load = ~dst_valid_o | dst_ready_i. The output register accepts a new beat when load=1.
//     This gives full throughput: back-to-back beats with no bubble while dst_ready_i=1.
//   - Pick: scan channels last_grant+1, +2, ... with wrap modulo NUM_CH. The first valid channel wins.
//     If no channel is valid, there is no grant.
//   - src_ready_o[w] = load & grant_valid for winner w, and 0 for every other channel.
//     src_ready_o does not depend on src_valid_i of other channels beyond the pick result.
//   - Transfer on channel w: src_valid_i[w] & src_ready_o[w]. The beat is registered into
//     dst_*_o on the same edge, dst_id_o=w, and last_grant<=w. Latency is 1 cycle from input to output.
//   - dst_ready_i=0 with dst_valid_o=1: the output holds stable, all src_ready_o=0, and last_grant holds.
//   - dst_valid_o falls only when load=1 and no transfer occurs.
//   - PKT_MODE=1: after a transfer with src_last_i[w]=0, lock<=1 and lock_id<=w.
//     While lock=1 only lock_id can win, even if it is idle and others are valid.
//     A transfer with last=1 on lock_id clears lock. A single-beat packet (last=1) never sets lock.
//   - Fairness: a continuously valid channel is granted within NUM_CH transfers (PKT_MODE=0),
//     or within NUM_CH packets (PKT_MODE=1).
//   - Only last_grant is updated on a transfer, never on an idle or stalled cycle.
//   - No X on any output after reset. Unselected data is never propagated.
//
// STRUCTURE
//   - Package rr_arb_pkg: function clog2_min1 (returns >= 1), and a parametrised typedef
//     for the channel index.
//   - Sub-module rr_pick #(NUM_CH): combinational rotating-priority picker.
//     Inputs: req vector, last_grant. Outputs: grant_valid and grant_id.
//     Implemented with the double-width mask/priority-encode method.
//   - Top level holds last_grant, lock, lock_id, the output register, and the ready generation.
//
// TESTING
//   1. Reset: NUM_CH=4, all src_valid=1 from the first edge -> grant order 0,1,2,3,0.
//      dst_id_o sequence matches; one beat per cycle with dst_ready_i=1.
//   2. Backpressure: ch2 valid with data 0xBEEF, dst_ready_i=0 for 5 cycles -> dst_data_o holds 0xBEEF,
//      src_ready_o=0000, last_grant unchanged. On release the next beat follows with no gap.
//   3. Sparse requests: only ch1 and ch3 valid, last_grant=3 -> order 1,3,1,3.
//      An idle cycle (no valid) drops dst_valid_o and leaves last_grant unchanged.
//   4. PKT_MODE=1: ch0 sends 3 beats (last on beat 3) while ch1 is always valid ->
//      three ch0 beats are contiguous, then ch1. A ch0 gap of 2 cycles mid-packet keeps ch1 blocked.
//   5. Reset mid-operation: assert areset_n=0 while dst_valid_o=1 and lock=1 ->
//      outputs zero immediately (async), lock cleared, and channel 0 wins first after release.
//   6. Random (NUM_CH=5, DATA_WIDTH=8): scoreboard checks per-channel order and no lost or duplicated beats,
//      src_ready_o one-hot-or-zero, and wait <= NUM_CH grants for a continuously valid channel.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared helpers and types for the N-channel round-robin arbiter.
package rr_arb_pkg;

    // Index width for n items, never below 1 bit so a 1-bit index is always legal.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    localparam int unsigned MAX_CH = 64;

    // Channel index wide enough for any supported channel count; modules narrow it to ID_W.
    typedef logic [clog2_min1(MAX_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/rr_arbiter_nch_pick.sv
// Combinational rotating-priority picker: first requester after last_grant, with wrap.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned ID_W   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [ID_W-1:0]   last_grant_i,
    output logic              grant_valid_o,
    output logic [ID_W-1:0]   grant_id_o
);

    localparam int unsigned DW2 = 2 * NUM_CH;

    logic [DW2-1:0] req_dbl;
    logic [DW2-1:0] mask;
    logic [DW2-1:0] masked;

    // Doubled request vector masked above last_grant; the upper copy supplies the wrap.
    always_comb begin
        req_dbl = {req_i, req_i};
        mask    = '0;
        for (int unsigned i = 0; i < DW2; i++) begin
            mask[i] = (i > 32'(last_grant_i));
        end
        masked = req_dbl & mask;
    end

    // Lowest set bit wins; scanning downward lets the lowest index overwrite.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        for (int unsigned i = DW2; i > 0; i--) begin
            if (masked[i-1]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = (i - 1 >= NUM_CH) ? ID_W'(i - 1 - NUM_CH) : ID_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_nch.sv
// N-channel round-robin arbiter with registered output stage and optional packet lock.
module rr_arbiter_nch
    import rr_arb_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 4,
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  bit          PKT_MODE   = 1'b0,
    localparam int unsigned ID_W       = clog2_min1(NUM_CH)
) (
    input  logic                         aclk,
    input  logic                         areset_n,
    input  logic [NUM_CH-1:0]            src_valid_i,
    output logic [NUM_CH-1:0]            src_ready_o,
    input  logic [NUM_CH*DATA_WIDTH-1:0] src_data_i,
    input  logic [NUM_CH-1:0]            src_last_i,
    output logic                         dst_valid_o,
    input  logic                         dst_ready_i,
    output logic [DATA_WIDTH-1:0]        dst_data_o,
    output logic                         dst_last_o,
    output logic [ID_W-1:0]              dst_id_o
);

    logic                  load_c;
    logic [NUM_CH-1:0]     req;
    logic                  grant_valid;
    logic [ID_W-1:0]       grant_id;

    logic [ID_W-1:0]       last_grant_q, last_grant_d;
    logic                  lock_q, lock_d;
    logic [ID_W-1:0]       lock_id_q, lock_id_d;
    logic                  dst_valid_q, dst_valid_d;
    logic [DATA_WIDTH-1:0] dst_data_q, dst_data_d;
    logic                  dst_last_q, dst_last_d;
    logic [ID_W-1:0]       dst_id_q, dst_id_d;

    assign load_c = ~dst_valid_q | dst_ready_i;

    // While a packet is open only its owner may compete, even when it idles.
    always_comb begin
        req = src_valid_i;
        if (lock_q) begin
            req            = '0;
            req[lock_id_q] = src_valid_i[lock_id_q];
        end
    end

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req_i         (req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    // A grant while the output stage can load is a transfer.
    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        dst_valid_d  = dst_valid_q;
        dst_data_d   = dst_data_q;
        dst_last_d   = dst_last_q;
        dst_id_d     = dst_id_q;
        src_ready_o  = '0;

        if (load_c) begin
            dst_valid_d = grant_valid;
            if (grant_valid) begin
                src_ready_o[grant_id] = 1'b1;
                dst_data_d   = src_data_i[32'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                dst_last_d   = src_last_i[grant_id];
                dst_id_d     = grant_id;
                last_grant_d = grant_id;
                if (PKT_MODE) begin
                    lock_d    = ~src_last_i[grant_id];
                    lock_id_d = grant_id;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            last_grant_q <= ID_W'(NUM_CH - 1);
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            dst_valid_q  <= 1'b0;
            dst_data_q   <= '0;
            dst_last_q   <= 1'b0;
            dst_id_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            dst_valid_q  <= dst_valid_d;
            dst_data_q   <= dst_data_d;
            dst_last_q   <= dst_last_d;
            dst_id_q     <= dst_id_d;
        end
    end

    assign dst_valid_o = dst_valid_q;
    assign dst_data_o  = dst_data_q;
    assign dst_last_o  = dst_last_q;
    assign dst_id_o    = dst_id_q;

endmodule

// File: tb/tb_rr_arbiter_nch.sv
// Scoreboard bench: three arbiter configurations, directed vectors plus a randomised run.
module tb_rr_arbiter_nch;

    localparam int unsigned NC = 5;

    typedef struct packed {
        logic [2:0]  id;
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // A: 4 ch, 16 bit, per-beat.  B: 4 ch, 16 bit, packet mode.  C: 5 ch, 8 bit, per-beat.
    logic        a_rst_n, a_dvalid, a_dready, a_dlast;
    logic [3:0]  a_valid, a_ready, a_last;
    logic [63:0] a_data;
    logic [15:0] a_ddata;
    logic [1:0]  a_did;

    logic        b_rst_n, b_dvalid, b_dready, b_dlast;
    logic [3:0]  b_valid, b_ready, b_last;
    logic [63:0] b_data;
    logic [15:0] b_ddata;
    logic [1:0]  b_did;

    logic        c_rst_n, c_dvalid, c_dready, c_dlast;
    logic [4:0]  c_valid, c_ready, c_last;
    logic [39:0] c_data;
    logic [7:0]  c_ddata;
    logic [2:0]  c_did;

    beat_t exp_a[$];
    beat_t exp_b[$];
    logic [7:0] exp_c [NC][32];
    int wr_c [NC];
    int rd_c [NC];

    rr_arbiter_nch #(.NUM_CH(4), .DATA_WIDTH(16), .PKT_MODE(1'b0)) u_a (
        .aclk(aclk), .areset_n(a_rst_n), .src_valid_i(a_valid), .src_ready_o(a_ready),
        .src_data_i(a_data), .src_last_i(a_last), .dst_valid_o(a_dvalid), .dst_ready_i(a_dready),
        .dst_data_o(a_ddata), .dst_last_o(a_dlast), .dst_id_o(a_did));

    rr_arbiter_nch #(.NUM_CH(4), .DATA_WIDTH(16), .PKT_MODE(1'b1)) u_b (
        .aclk(aclk), .areset_n(b_rst_n), .src_valid_i(b_valid), .src_ready_o(b_ready),
        .src_data_i(b_data), .src_last_i(b_last), .dst_valid_o(b_dvalid), .dst_ready_i(b_dready),
        .dst_data_o(b_ddata), .dst_last_o(b_dlast), .dst_id_o(b_did));

    rr_arbiter_nch #(.NUM_CH(NC), .DATA_WIDTH(8), .PKT_MODE(1'b0)) u_c (
        .aclk(aclk), .areset_n(c_rst_n), .src_valid_i(c_valid), .src_ready_o(c_ready),
        .src_data_i(c_data), .src_last_i(c_last), .dst_valid_o(c_dvalid), .dst_ready_i(c_dready),
        .dst_data_o(c_ddata), .dst_last_o(c_dlast), .dst_id_o(c_did));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Output monitors: an accepted beat must match the front of the scoreboard.
    always @(negedge aclk) begin : mon_a
        beat_t e;
        if (a_rst_n && a_dvalid && a_dready) begin
            if (exp_a.size() == 0) begin
                chk("a_extra_beat", 32'(beat_t'{3'(a_did), a_ddata, a_dlast}), 32'hFFFF_FFFF);
            end else begin
                e = exp_a.pop_front();
                chk("a_beat", 32'(beat_t'{3'(a_did), a_ddata, a_dlast}), 32'(e));
            end
        end
    end

    always @(negedge aclk) begin : mon_b
        beat_t e;
        if (b_rst_n && b_dvalid && b_dready) begin
            if (exp_b.size() == 0) begin
                chk("b_extra_beat", 32'(beat_t'{3'(b_did), b_ddata, b_dlast}), 32'hFFFF_FFFF);
            end else begin
                e = exp_b.pop_front();
                chk("b_beat", 32'(beat_t'{3'(b_did), b_ddata, b_dlast}), 32'(e));
            end
        end
    end

    always @(negedge aclk) begin : mon_c
        int id;
        if (c_rst_n && c_dvalid && c_dready) begin
            id = int'(c_did);
            if (id >= int'(NC) || rd_c[id] >= wr_c[id]) begin
                chk("c_unexpected_beat", 32'({c_did, c_ddata}), 32'hFFFF_FFFF);
            end else begin
                chk("c_chan_order", 32'(c_ddata), 32'(exp_c[id][rd_c[id] % 32]));
                rd_c[id]++;
            end
        end
    end

    initial begin : stim
        logic [4:0] acc;
        int         wait_c [NC];
        int         seq_c [NC];
        logic [7:0] d;

        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
        a_valid = '0; a_data = '0; a_last = '0; a_dready = 1'b1;
        b_valid = '0; b_data = '0; b_last = '0; b_dready = 1'b1;
        c_valid = '0; c_data = '0; c_last = '0; c_dready = 1'b0;
        for (int i = 0; i < int'(NC); i++) begin
            wr_c[i] = 0; rd_c[i] = 0; wait_c[i] = 0; seq_c[i] = 0;
        end
        #2;
        chk("rst_a_out", 32'({a_dvalid, a_ddata, a_dlast, a_did}), 32'h0);
        chk("rst_b_out", 32'({b_dvalid, b_ddata, b_dlast, b_did}), 32'h0);
        chk("rst_c_out", 32'({c_dvalid, c_ddata, c_dlast, c_did}), 32'h0);

        // Reset release with every channel requesting: 0,1,2,3,0 back to back.
        step();
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        for (int ch = 0; ch < 4; ch++) a_data[ch*16 +: 16] = 16'(16'h1000 + ch);
        a_valid = 4'hF;
        #1 chk("t1_first_ready", 32'(a_ready), 32'h1);
        for (int k = 0; k < 5; k++) exp_a.push_back(beat_t'{3'(k % 4), 16'(16'h1000 + k % 4), 1'b0});
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t1_dvalid", 32'(a_dvalid), 32'h1);
            chk("t1_id_seq", 32'(a_did), 32'(k % 4));
        end
        a_valid = '0;
        step();
        chk("t1_idle_drop", 32'(a_dvalid), 32'h0);

        // Backpressure: BEEF holds for five stalled cycles, then BEF0 follows without a bubble.
        a_valid = 4'b0100; a_data[32 +: 16] = 16'hBEEF; a_dready = 1'b0;
        exp_a.push_back(beat_t'{3'd2, 16'hBEEF, 1'b0});
        exp_a.push_back(beat_t'{3'd2, 16'hBEF0, 1'b0});
        step();
        a_data[32 +: 16] = 16'hBEF0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_hold_valid", 32'(a_dvalid), 32'h1);
            chk("t2_hold_data", 32'(a_ddata), 32'hBEEF);
            chk("t2_ready_zero", 32'(a_ready), 32'h0);
            step();
        end
        a_dready = 1'b1;
        #1 chk("t2_release_ready", 32'(a_ready), 32'h4);
        step();
        chk("t2_no_gap_valid", 32'(a_dvalid), 32'h1);
        chk("t2_no_gap_data", 32'(a_ddata), 32'hBEF0);
        a_valid = '0;
        step();

        // Sparse requests after a ch3 grant: 1,3,1,3, an idle cycle, then ch1 again.
        a_valid = 4'b1000; a_data[48 +: 16] = 16'h3003;
        exp_a.push_back(beat_t'{3'd3, 16'h3003, 1'b0});
        step();
        a_valid = 4'b1010; a_data[16 +: 16] = 16'h1111; a_data[48 +: 16] = 16'h3333;
        for (int k = 0; k < 4; k++)
            exp_a.push_back(beat_t'{(k % 2 == 1) ? 3'd3 : 3'd1, (k % 2 == 1) ? 16'h3333 : 16'h1111, 1'b0});
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_sparse_id", 32'(a_did), (k % 2 == 1) ? 32'd3 : 32'd1);
        end
        a_valid = '0;
        step();
        chk("t3_idle_drop", 32'(a_dvalid), 32'h0);
        a_valid = 4'b1010;
        #1 chk("t3_grant_after_idle", 32'(a_ready), 32'h2);
        exp_a.push_back(beat_t'{3'd1, 16'h1111, 1'b0});
        step();
        a_valid = '0;
        step();

        // Packet mode: ch0 owns the sink across a 2-cycle gap while ch1 keeps requesting.
        b_valid = 4'b0011; b_data[0 +: 16] = 16'hA001; b_data[16 +: 16] = 16'hB001; b_last = 4'b0010;
        #1 chk("t4_first_ready", 32'(b_ready), 32'h1);
        exp_b.push_back(beat_t'{3'd0, 16'hA001, 1'b0});
        step();
        b_valid = 4'b0010;
        #1 chk("t4_locked_gap1", 32'(b_ready), 32'h0);
        step();
        chk("t4_gap_drop", 32'(b_dvalid), 32'h0);
        chk("t4_locked_gap2", 32'(b_ready), 32'h0);
        step();
        b_valid = 4'b0011; b_data[0 +: 16] = 16'hA002;
        exp_b.push_back(beat_t'{3'd0, 16'hA002, 1'b0});
        #1 chk("t4_resume_ready", 32'(b_ready), 32'h1);
        step();
        b_data[0 +: 16] = 16'hA003; b_last = 4'b0011;
        exp_b.push_back(beat_t'{3'd0, 16'hA003, 1'b1});
        step();
        b_valid = 4'b0010;
        exp_b.push_back(beat_t'{3'd1, 16'hB001, 1'b1});
        #1 chk("t4_unlocked_ready", 32'(b_ready), 32'h2);
        step();

        // Reset while a locked beat sits in the output register.
        b_valid = 4'b0011; b_data[0 +: 16] = 16'hA010; b_last = 4'b0010;
        step();
        b_dready = 1'b0; b_valid = '0;
        chk("t5_pre_valid", 32'(b_dvalid), 32'h1);
        chk("t5_pre_id", 32'(b_did), 32'h0);
        b_rst_n = 1'b0;
        #1 chk("t5_async_clear", 32'({b_dvalid, b_ddata, b_dlast, b_did}), 32'h0);
        b_rst_n = 1'b1;
        step();
        b_dready = 1'b1; b_valid = 4'b0010; b_last = 4'b0011;
        b_data[0 +: 16] = 16'hA020; b_data[16 +: 16] = 16'hB020;
        #1 chk("t5_lock_cleared", 32'(b_ready), 32'h2);
        b_valid = 4'b0011;
        #1 chk("t5_ch0_first", 32'(b_ready), 32'h1);
        exp_b.push_back(beat_t'{3'd0, 16'hA020, 1'b1});
        exp_b.push_back(beat_t'{3'd1, 16'hB020, 1'b1});
        step();
        step();
        b_valid = '0;
        step();

        // Randomised traffic on the 5-channel instance.
        c_dready = 1'b1;
        for (int cyc = 0; cyc < 320; cyc++) begin
            @(negedge aclk);
            acc = c_valid & c_ready;
            chk("t6_ready_onehot0", 32'($onehot0(c_ready)), 32'h1);
            if (acc != '0) begin
                for (int ch = 0; ch < int'(NC); ch++) begin
                    if (acc[ch]) begin
                        chk("t6_fair_wait", 32'(wait_c[ch] <= int'(NC) - 1), 32'h1);
                        wait_c[ch] = 0;
                    end else if (c_valid[ch]) begin
                        wait_c[ch]++;
                    end
                end
            end
            @(posedge aclk);
            #1;
            for (int ch = 0; ch < int'(NC); ch++) begin
                if (acc[ch]) c_valid[ch] = 1'b0;
                if (!c_valid[ch] && cyc < 290 && $urandom_range(3, 0) != 0) begin
                    d = {3'(ch), 5'(seq_c[ch])};
                    seq_c[ch]++;
                    c_data[ch*8 +: 8] = d;
                    exp_c[ch][wr_c[ch] % 32] = d;
                    wr_c[ch]++;
                    c_valid[ch] = 1'b1;
                end
            end
            c_dready = (cyc >= 290) || ($urandom_range(3, 0) != 0);
        end
        step();
        chk("t6_sources_drained", 32'(c_valid), 32'h0);
        chk("t6_out_drained", 32'(c_dvalid), 32'h0);
        for (int ch = 0; ch < int'(NC); ch++)
            chk("t6_no_lost_beat", 32'(rd_c[ch]), 32'(wr_c[ch]));

        chk("a_scoreboard_empty", 32'(exp_a.size()), 32'h0);
        chk("b_scoreboard_empty", 32'(exp_b.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
